piso_ser_ctrl: RTL and testbench

- Sequences a WIDTH-bit parallel-in/serial-out shift register.
- Accepts parallel words over a valid/ready handshake into a one-word holding buffer.
- Issues the load and shift operations to the shift register, and frames the serial stream with first-bit and last-bit strobes.
- Sits between a word producer and a bit-serial consumer that can stall via ser_en.

---
 rtl/piso_ser_ctrl_if.sv | 25 ++
 rtl/piso_ser_ctrl.sv | 155 +++++++++++++++
 tb/tb_piso_ser_ctrl.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/piso_ser_ctrl_if.sv
// Producer handshake and bit-serial consumer bundle for piso_ser_ctrl.
// master = the environment side, slave = the controller side.
interface piso_ser_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             ser_en;
  logic             sout;
  logic             sout_valid;
  logic             sof;
  logic             eof;
  logic             busy;

  modport master (
    output in_valid, in_data, ser_en,
    input  in_ready, sout, sout_valid, sof, eof, busy
  );

  modport slave (
    input  in_valid, in_data, ser_en,
    output in_ready, sout, sout_valid, sof, eof, busy
  );
endinterface

// File: rtl/piso_ser_ctrl.sv
// Parallel-in/serial-out sequencer: one-word holding buffer, shift register and
// IDLE/SHIFT/GAP framing FSM with first/last-bit strobes. All outputs registered.
module piso_ser_ctrl #(
  parameter int          WIDTH     = 4,
  parameter int unsigned GAP       = 0,
  parameter bit          LSB_FIRST = 1'b1
) (
  input logic            clk,
  input logic            rst_n,
  piso_ser_ctrl_if.slave bus
);
  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam bit               HAS_GAP  = (GAP > 0);
  localparam logic [7:0]       GAP_LOAD = HAS_GAP ? 8'(GAP - 1) : 8'd0;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       gap_q, gap_d;
  logic [WIDTH-1:0] hold_buf_q, hold_buf_d;
  logic             hold_full_q, hold_full_d;
  logic             in_ready_q, in_ready_d;
  logic             sout_q, sout_d;
  logic             sout_valid_q, sout_valid_d;
  logic             sof_q, sof_d;
  logic             eof_q, eof_d;
  logic             busy_q, busy_d;
  logic             load_s;
  logic             accept_s;

  function automatic logic out_bit(input logic [WIDTH-1:0] sr);
    return LSB_FIRST ? sr[0] : sr[WIDTH-1];
  endfunction

  function automatic logic [WIDTH-1:0] shift_next(input logic [WIDTH-1:0] sr);
    return LSB_FIRST ? {1'b0, sr[WIDTH-1:1]} : {sr[WIDTH-2:0], 1'b0};
  endfunction

  assign accept_s = bus.in_valid & in_ready_q;

  // Framing FSM, shift datapath and holding-buffer next state.
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    gap_d       = gap_q;
    hold_buf_d  = hold_buf_q;
    hold_full_d = hold_full_q;
    load_s      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (hold_full_q) begin
          load_s = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (!bus.ser_en) begin
          state_d = S_SHIFT;
        end else if (cnt_q != CNT_LAST) begin
          sr_d  = shift_next(sr_q);
          cnt_d = cnt_q + CNT_ONE;
        end else if (HAS_GAP) begin
          state_d = S_GAP;
          gap_d   = GAP_LOAD;
        end else if (hold_full_q) begin
          load_s = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GAP: begin
        if (gap_q != 8'd0) begin
          gap_d = gap_q - 8'd1;
        end else if (hold_full_q) begin
          load_s = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A load needs hold_full and an accept needs it clear, so they are exclusive.
    if (load_s) begin
      sr_d        = hold_buf_q;
      cnt_d       = {CNT_W{1'b0}};
      state_d     = S_SHIFT;
      hold_full_d = 1'b0;
    end else if (accept_s) begin
      hold_buf_d  = bus.in_data;
      hold_full_d = 1'b1;
    end else begin
      hold_full_d = hold_full_q;
    end
  end

  // Output decode from next state so every port comes straight from a flop.
  always_comb begin
    sout_valid_d = (state_d == S_SHIFT);
    sout_d       = sout_valid_d & out_bit(sr_d);
    sof_d        = sout_valid_d & (cnt_d == {CNT_W{1'b0}});
    eof_d        = sout_valid_d & (cnt_d == CNT_LAST);
    busy_d       = (state_d != S_IDLE) | hold_full_d;
    in_ready_d   = ~hold_full_d;
  end

  // State and output registers; reset also discards any in-flight frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      sr_q         <= {WIDTH{1'b0}};
      cnt_q        <= {CNT_W{1'b0}};
      gap_q        <= 8'd0;
      hold_buf_q   <= {WIDTH{1'b0}};
      hold_full_q  <= 1'b0;
      in_ready_q   <= 1'b0;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      sof_q        <= 1'b0;
      eof_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      cnt_q        <= cnt_d;
      gap_q        <= gap_d;
      hold_buf_q   <= hold_buf_d;
      hold_full_q  <= hold_full_d;
      in_ready_q   <= in_ready_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      sof_q        <= sof_d;
      eof_q        <= eof_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.sout       = sout_q;
  assign bus.sout_valid = sout_valid_q;
  assign bus.sof        = sof_q;
  assign bus.eof        = eof_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_piso_ser_ctrl.sv
// Bench for piso_ser_ctrl: three instances (GAP=0/LSB, GAP=2/LSB, GAP=0/MSB) share
// stimulus and are each checked every cycle against a word/bit-position model.
module tb_piso_ser_ctrl;
  logic       clk;
  logic       rst_n;
  logic       tb_valid;
  logic [3:0] tb_data;
  logic       tb_ser_en;

  int total = 0;
  int bad   = 0;

  piso_ser_ctrl_if #(.WIDTH(4)) bus0();
  piso_ser_ctrl_if #(.WIDTH(4)) bus1();
  piso_ser_ctrl_if #(.WIDTH(4)) bus2();

  piso_ser_ctrl #(.WIDTH(4), .GAP(0), .LSB_FIRST(1'b1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  piso_ser_ctrl #(.WIDTH(4), .GAP(2), .LSB_FIRST(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  piso_ser_ctrl #(.WIDTH(4), .GAP(0), .LSB_FIRST(1'b0)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  assign bus0.in_valid = tb_valid;  assign bus0.in_data = tb_data;  assign bus0.ser_en = tb_ser_en;
  assign bus1.in_valid = tb_valid;  assign bus1.in_data = tb_data;  assign bus1.ser_en = tb_ser_en;
  assign bus2.in_valid = tb_valid;  assign bus2.in_data = tb_data;  assign bus2.ser_en = tb_ser_en;

  logic [2:0] a_valid, a_sout, a_sof, a_eof, a_rdy, a_busy;
  assign a_valid = {bus2.sout_valid, bus1.sout_valid, bus0.sout_valid};
  assign a_sout  = {bus2.sout, bus1.sout, bus0.sout};
  assign a_sof   = {bus2.sof, bus1.sof, bus0.sof};
  assign a_eof   = {bus2.eof, bus1.eof, bus0.eof};
  assign a_rdy   = {bus2.in_ready, bus1.in_ready, bus0.in_ready};
  assign a_busy  = {bus2.busy, bus1.busy, bus0.busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a frame in flight (word + bit position), an optional
  // buffered word, and the number of idle gap cycles still to run.
  int         gapp[3] = '{0, 2, 0};
  bit         lsbf[3] = '{1'b1, 1'b1, 1'b0};
  bit         m_frame[3];
  logic [3:0] m_word[3];
  int         m_pos[3];
  bit         m_buf_full[3];
  logic [3:0] m_buf[3];
  int         m_gap[3];
  bit         m_rdy[3];

  typedef struct {
    logic       v;
    logic [3:0] d;
    logic       se;
    logic       e_valid;
    logic       e_sout;
    logic       e_sof;
    logic       e_eof;
    logic       e_rdy;
    logic       e_busy;
  } vec_t;
  vec_t tv[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_frame[d] = 1'b0; m_word[d] = 4'd0; m_pos[d] = 0;
      m_buf_full[d] = 1'b0; m_buf[d] = 4'd0; m_gap[d] = 0; m_rdy[d] = 1'b0;
    end
  endtask

  task automatic model_edge(input int d);
    bit acc;
    bit pop;
    acc = tb_valid && m_rdy[d] && !m_buf_full[d];
    pop = 1'b0;
    if (m_frame[d]) begin
      if (tb_ser_en) begin
        if (m_pos[d] < 3) m_pos[d]++;
        else begin
          m_frame[d] = 1'b0;
          if (gapp[d] > 0) m_gap[d] = gapp[d];
          else pop = m_buf_full[d];
        end
      end
    end else if (m_gap[d] > 0) begin
      if (m_gap[d] == 1) pop = m_buf_full[d];
      m_gap[d]--;
    end else begin
      pop = m_buf_full[d];
    end
    if (pop) begin
      m_frame[d] = 1'b1; m_word[d] = m_buf[d]; m_pos[d] = 0; m_buf_full[d] = 1'b0;
    end
    if (acc) begin
      m_buf[d] = tb_data; m_buf_full[d] = 1'b1;
    end
    m_rdy[d] = 1'b1;
  endtask

  function automatic logic m_bit(input int d);
    logic [3:0] w;
    w = m_word[d];
    return lsbf[d] ? w[m_pos[d]] : w[3 - m_pos[d]];
  endfunction

  task automatic check_model(input int d);
    chk($sformatf("d%0d sout_valid", d), a_valid[d], m_frame[d]);
    chk($sformatf("d%0d sout", d), a_sout[d], m_frame[d] & m_bit(d));
    chk($sformatf("d%0d sof", d), a_sof[d], m_frame[d] && m_pos[d] == 0);
    chk($sformatf("d%0d eof", d), a_eof[d], m_frame[d] && m_pos[d] == 3);
    chk($sformatf("d%0d in_ready", d), a_rdy[d], m_rdy[d] && !m_buf_full[d]);
    chk($sformatf("d%0d busy", d), a_busy[d], m_frame[d] || m_gap[d] > 0 || m_buf_full[d]);
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) for (int d = 0; d < 3; d++) model_edge(d);
    #1;
    for (int d = 0; d < 3; d++) check_model(d);
  endtask

  task automatic drive(input logic v, input logic [3:0] dt, input logic se);
    tb_valid = v; tb_data = dt; tb_ser_en = se;
  endtask

  task automatic add(input logic v, input logic [3:0] d, input logic se, input logic ev,
                     input logic es, input logic ef, input logic ee, input logic er, input logic eb);
    vec_t r;
    r.v = v; r.d = d; r.se = se; r.e_valid = ev; r.e_sout = es;
    r.e_sof = ef; r.e_eof = ee; r.e_rdy = er; r.e_busy = eb;
    tv.push_back(r);
  endtask

  logic [15:0] rv, rs, rf, re;
  logic [9:0]  gap_valid_pat;
  logic [9:0]  gap_sout_pat;
  int          s;
  int          eof_seen;

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 4'd0, 1'b1);
    model_reset();

    // 1011 LSB-first: 1,1,0,1 then idle.
    add(1'b1, 4'hB, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    add(1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    add(1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    add(1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    add(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    // A then 5 back-to-back: 0,1,0,1,1,0,1,0 with no bubble.
    add(1'b1, 4'hA, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b1, 4'h5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    add(1'b1, 4'h5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    add(1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    add(1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    add(1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    add(1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    add(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    // 0110 with a 3-cycle stall after the 2nd bit: frame spans 7 cycles.
    add(1'b1, 4'h6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    add(1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    add(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    add(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    add(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    add(1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    add(1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    add(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset state while rst_n is held low.
    for (int i = 0; i < 3; i++) step();
    chk("rst in_ready", a_rdy, 3'b000);
    chk("rst sout_valid", a_valid, 3'b000);
    chk("rst busy", a_busy, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post-rst in_ready", a_rdy, 3'b111);

    foreach (tv[i]) begin
      drive(tv[i].v, tv[i].d, tv[i].se);
      step();
      chk($sformatf("vec%0d sout_valid", i), a_valid[0], tv[i].e_valid);
      chk($sformatf("vec%0d sout", i), a_sout[0], tv[i].e_sout);
      chk($sformatf("vec%0d sof", i), a_sof[0], tv[i].e_sof);
      chk($sformatf("vec%0d eof", i), a_eof[0], tv[i].e_eof);
      chk($sformatf("vec%0d in_ready", i), a_rdy[0], tv[i].e_rdy);
      chk($sformatf("vec%0d busy", i), a_busy[0], tv[i].e_busy);
    end
    drive(1'b0, 4'd0, 1'b1);
    for (int i = 0; i < 8; i++) step();

    // GAP=2 instance: 3 then C preloaded -> eof, 2 empty cycles, sof.
    for (int i = 0; i < 16; i++) begin
      if (i == 0) drive(1'b1, 4'h3, 1'b1);
      else if (i < 3) drive(1'b1, 4'hC, 1'b1);
      else drive(1'b0, 4'h0, 1'b1);
      step();
      rv[i] = a_valid[1]; rs[i] = a_sout[1]; rf[i] = a_sof[1]; re[i] = a_eof[1];
    end
    s = -1;
    for (int i = 15; i >= 0; i--) if (rf[i]) s = i;
    gap_valid_pat = 10'b1111001111;
    gap_sout_pat  = 10'b1100000011;
    if (s < 0 || s > 6) begin
      chk("gap first sof index", s, 1);
    end else begin
      for (int k = 0; k < 10; k++) begin
        chk($sformatf("gap valid[%0d]", k), rv[s + k], gap_valid_pat[k]);
        chk($sformatf("gap sout[%0d]", k), rs[s + k], gap_sout_pat[k]);
      end
      chk("gap eof1", re[s + 3], 1'b1);
      chk("gap sof2", rf[s + 6], 1'b1);
      chk("gap eof2", re[s + 9], 1'b1);
    end

    // MSB-first instance: 1000 -> 1,0,0,0.
    for (int i = 0; i < 10; i++) begin
      if (i == 0) drive(1'b1, 4'h8, 1'b1);
      else drive(1'b0, 4'h0, 1'b1);
      step();
      rv[i] = a_valid[2]; rs[i] = a_sout[2]; rf[i] = a_sof[2]; re[i] = a_eof[2];
    end
    s = -1;
    for (int i = 9; i >= 0; i--) if (rf[i]) s = i;
    if (s < 0 || s > 6) begin
      chk("msb first sof index", s, 1);
    end else begin
      chk("msb valid run", {rv[s + 3], rv[s + 2], rv[s + 1], rv[s]}, 4'b1111);
      chk("msb sout run", {rs[s + 3], rs[s + 2], rs[s + 1], rs[s]}, 4'b0001);
      chk("msb eof", re[s + 3], 1'b1);
    end

    // Randomised traffic with stalls, checked by the model on all instances.
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom % 3) != 0, 4'($urandom), ($urandom % 4) != 0);
      step();
    end
    drive(1'b0, 4'd0, 1'b1);
    for (int i = 0; i < 20; i++) step();

    // Async reset during the 3rd bit with a second word buffered.
    drive(1'b1, 4'hA, 1'b1); step();
    drive(1'b1, 4'h5, 1'b1); step();
    step();
    drive(1'b0, 4'h0, 1'b1); step();
    chk("pre-abort busy", a_busy[0], 1'b1);
    chk("pre-abort in_ready", a_rdy[0], 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("abort sout_valid", a_valid, 3'b000);
    chk("abort busy", a_busy, 3'b000);
    chk("abort in_ready", a_rdy, 3'b000);
    chk("abort eof", a_eof, 3'b000);
    model_reset();
    step();
    step();
    @(negedge clk);
    rst_n = 1'b1;
    eof_seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (a_eof != 3'b000 || a_valid != 3'b000) eof_seen++;
    end
    chk("after abort in_ready", a_rdy, 3'b111);
    chk("after abort silent", eof_seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
